// File: rtl/pux_si_pkg.sv
// Shared encodings for the PUX streaming instruction front-end.
package pux_si_pkg;

  // Opcode field layout
  localparam int unsigned OP_LSB      = 0;
  localparam int unsigned OP_W        = 4;
  localparam int unsigned LEN_LSB     = 4;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned OPC_FIELD_W = 8;
  localparam int unsigned STATUS_W    = 2;

  // Operation codes
  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_CMP = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB = 4'd3;

  // Status codes
  localparam logic [STATUS_W-1:0] ST_LT  = 2'b00;
  localparam logic [STATUS_W-1:0] ST_EQ  = 2'b01;
  localparam logic [STATUS_W-1:0] ST_GT  = 2'b10;
  localparam logic [STATUS_W-1:0] ST_ERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_STREAM = 2'd2,
    S_STATUS = 2'd3
  } state_e;

endpackage

// File: rtl/pux_si_wordcmp.sv
// Per-word add/sub with carry chaining and three-way compare against M.
// Subtract path exists only when PUX_SI_SUB_EN is defined.
module pux_si_wordcmp
  import pux_si_pkg::*;
#(
  parameter int unsigned DATAW = 16
) (
  input  logic [DATAW-1:0]    a,
  input  logic [DATAW-1:0]    b,
  input  logic [DATAW-1:0]    m,
  input  logic                use_b,
  input  logic                sub,
  input  logic                cin,
  input  logic [STATUS_W-1:0] cmp_prev,
  output logic                cout,
  output logic [STATUS_W-1:0] cmp_next
);

  logic [DATAW:0]   sum;
  logic [DATAW-1:0] b_eff;
  logic [DATAW-1:0] r;

`ifdef PUX_SI_SUB_EN
  logic [DATAW:0] diff;
`else
  logic unused_sub;
  assign unused_sub = sub;
`endif

  // Word result, carry/borrow out, and compare merged with the lower words
  always_comb begin
    b_eff = use_b ? b : '0;
    sum   = {1'b0, a} + {1'b0, b_eff} + (DATAW+1)'(cin);
    r     = sum[DATAW-1:0];
    cout  = sum[DATAW];
`ifdef PUX_SI_SUB_EN
    diff  = {1'b0, a} - {1'b0, b} - (DATAW+1)'(cin);
    if (sub) begin
      r    = diff[DATAW-1:0];
      cout = diff[DATAW];
    end
`endif
    if (r > m) begin
      cmp_next = ST_GT;
    end else if (r < m) begin
      cmp_next = ST_LT;
    end else begin
      cmp_next = cmp_prev;
    end
  end

endmodule

// File: rtl/pux_si.sv
// PUX streaming instruction front-end: opcode in, A/B/M word streams in,
// 2-bit compare status out. Define PUX_SI_SUB_EN to implement SUBCMP (OP 3).
module pux_si
  import pux_si_pkg::*;
#(
  parameter int unsigned OPCW  = 8,
  parameter int unsigned DATAW = 16
) (
  input  logic                axis_clk,
  input  logic                axis_rstn,
  input  logic [OPCW-1:0]     axis_opcode_data,
  input  logic                axis_opcode_valid,
  output logic                axis_opcode_ready,
  input  logic [DATAW-1:0]    axis_abuff_data,
  input  logic                axis_abuff_valid,
  output logic                axis_abuff_ready,
  input  logic [DATAW-1:0]    axis_bbuff_data,
  input  logic                axis_bbuff_valid,
  output logic                axis_bbuff_ready,
  input  logic [DATAW-1:0]    axis_mbuff_data,
  input  logic                axis_mbuff_valid,
  output logic                axis_mbuff_ready,
  input  logic                axis_status_ready,
  output logic [STATUS_W-1:0] axis_status_data,
  output logic                axis_status_valid,
  output logic                stream_reqest
);

  state_e              state;
  logic [OP_W-1:0]     op_q;
  logic [LEN_W-1:0]    len_m1_q;
  logic [LEN_W-1:0]    count_q;
  logic                carry_q;
  logic [STATUS_W-1:0] cmp_q;

  logic [OP_W-1:0]     op_in;
  logic                op_ok;
  logic                opc_fire;
  logic                use_b;
  logic                is_sub;
  logic                beat;
  logic                last_beat;
  logic                word_cout;
  logic [STATUS_W-1:0] word_cmp;
  logic [STATUS_W-1:0] final_st;

  // Opcode decode: upper bits must be clear and OP must be implemented
  always_comb begin
    op_in = axis_opcode_data[OP_LSB +: OP_W];
    op_ok = 1'b0;
    if ((axis_opcode_data >> OPC_FIELD_W) == '0) begin
      case (op_in)
        OP_NOP, OP_CMP, OP_ADD: op_ok = 1'b1;
`ifdef PUX_SI_SUB_EN
        OP_SUB:                 op_ok = 1'b1;
`endif
        default:                op_ok = 1'b0;
      endcase
    end
  end

  // Which streams the in-flight operation consumes
  always_comb begin
    use_b  = (op_q == OP_ADD);
    is_sub = 1'b0;
`ifdef PUX_SI_SUB_EN
    is_sub = (op_q == OP_SUB);
    use_b  = use_b | is_sub;
`endif
  end

  // All-or-nothing beat handshake; readys are held low while in reset
  always_comb begin
    axis_opcode_ready = (state == S_IDLE) && !axis_rstn;
    opc_fire          = axis_opcode_ready && axis_opcode_valid;
    beat              = (state == S_STREAM) && !axis_rstn &&
                        axis_abuff_valid && axis_mbuff_valid &&
                        (axis_bbuff_valid || !use_b);
    axis_abuff_ready  = beat;
    axis_mbuff_ready  = beat;
    axis_bbuff_ready  = beat && use_b;
    last_beat         = (count_q == len_m1_q);
  end

  pux_si_wordcmp #(
    .DATAW (DATAW)
  ) u_wordcmp (
    .a        (axis_abuff_data),
    .b        (axis_bbuff_data),
    .m        (axis_mbuff_data),
    .use_b    (use_b),
    .sub      (is_sub),
    .cin      (carry_q),
    .cmp_prev (cmp_q),
    .cout     (word_cout),
    .cmp_next (word_cmp)
  );

  // Final status: overflow out of the top word overrides the word compare
  always_comb begin
    final_st = word_cmp;
    if ((op_q == OP_ADD) && word_cout) begin
      final_st = ST_GT;
    end
    if (is_sub && word_cout) begin
      final_st = ST_LT;
    end
  end

  // Control FSM with registered status and fetch request
  always_ff @(posedge axis_clk) begin
    if (axis_rstn) begin
      state             <= S_IDLE;
      op_q              <= OP_NOP;
      len_m1_q          <= '0;
      count_q           <= '0;
      carry_q           <= 1'b0;
      cmp_q             <= ST_EQ;
      axis_status_data  <= '0;
      axis_status_valid <= 1'b0;
      stream_reqest     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (opc_fire) begin
            if (!op_ok) begin
              axis_status_data  <= ST_ERR;
              axis_status_valid <= 1'b1;
              state             <= S_STATUS;
            end else if (op_in == OP_NOP) begin
              axis_status_data  <= ST_EQ;
              axis_status_valid <= 1'b1;
              state             <= S_STATUS;
            end else begin
              op_q          <= op_in;
              len_m1_q      <= axis_opcode_data[LEN_LSB +: LEN_W];
              stream_reqest <= 1'b1;
              state         <= S_REQ;
            end
          end
        end
        S_REQ: begin
          stream_reqest <= 1'b0;
          cmp_q         <= ST_EQ;
          carry_q       <= 1'b0;
          count_q       <= '0;
          state         <= S_STREAM;
        end
        S_STREAM: begin
          if (beat) begin
            carry_q <= word_cout;
            cmp_q   <= word_cmp;
            count_q <= count_q + LEN_W'(1);
            if (last_beat) begin
              axis_status_data  <= final_st;
              axis_status_valid <= 1'b1;
              state             <= S_STATUS;
            end
          end
        end
        S_STATUS: begin
          if (axis_status_ready) begin
            axis_status_valid <= 1'b0;
            state             <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pux_si.sv
// Scoreboard bench for pux_si: stimulus pushes expected status codes,
// a negedge monitor pops and compares on each status handshake.
module tb_pux_si;

  logic        axis_clk;
  logic        axis_rstn;
  logic [7:0]  axis_opcode_data;
  logic        axis_opcode_valid;
  logic        axis_opcode_ready;
  logic [15:0] axis_abuff_data;
  logic        axis_abuff_valid;
  logic        axis_abuff_ready;
  logic [15:0] axis_bbuff_data;
  logic        axis_bbuff_valid;
  logic        axis_bbuff_ready;
  logic [15:0] axis_mbuff_data;
  logic        axis_mbuff_valid;
  logic        axis_mbuff_ready;
  logic        axis_status_ready;
  logic [1:0]  axis_status_data;
  logic        axis_status_valid;
  logic        stream_reqest;

  int checks   = 0;
  int failures = 0;
  int req_cnt  = 0;
  int beat_cnt = 0;
  bit ready_seen = 0;
  logic [1:0] exp_q[$];
  logic [1:0] popped;
  logic [15:0] wa[16];
  logic [15:0] wb[16];
  logic [15:0] wm[16];

  pux_si #(.OPCW(8), .DATAW(16)) dut (
    .axis_clk          (axis_clk),
    .axis_rstn         (axis_rstn),
    .axis_opcode_data  (axis_opcode_data),
    .axis_opcode_valid (axis_opcode_valid),
    .axis_opcode_ready (axis_opcode_ready),
    .axis_abuff_data   (axis_abuff_data),
    .axis_abuff_valid  (axis_abuff_valid),
    .axis_abuff_ready  (axis_abuff_ready),
    .axis_bbuff_data   (axis_bbuff_data),
    .axis_bbuff_valid  (axis_bbuff_valid),
    .axis_bbuff_ready  (axis_bbuff_ready),
    .axis_mbuff_data   (axis_mbuff_data),
    .axis_mbuff_valid  (axis_mbuff_valid),
    .axis_mbuff_ready  (axis_mbuff_ready),
    .axis_status_ready (axis_status_ready),
    .axis_status_data  (axis_status_data),
    .axis_status_valid (axis_status_valid),
    .stream_reqest     (stream_reqest)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: count requests/beats and score every status handshake
  always @(negedge axis_clk) begin
    if (stream_reqest) req_cnt++;
    if (axis_abuff_valid && axis_abuff_ready) beat_cnt++;
    if (axis_abuff_ready || axis_bbuff_ready || axis_mbuff_ready) ready_seen = 1;
    if (axis_status_valid && axis_status_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_status actual=%0h expected=none", axis_status_data);
      end else begin
        popped = exp_q.pop_front();
        chk("status_data", 32'(axis_status_data), 32'(popped));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_opcode(input logic [7:0] opc);
    bit ok = 0;
    axis_opcode_data  = opc;
    axis_opcode_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge axis_clk);
      if (axis_opcode_ready) begin ok = 1; break; end
    end
    chk("opcode_accept", 32'(ok), 32'd1);
    @(posedge axis_clk); #1;
    axis_opcode_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge axis_clk); #1;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // NOP / invalid opcodes: status next cycle, no stream activity
  task automatic run_short(input logic [7:0] opc, input logic [1:0] exp);
    int req0 = req_cnt;
    ready_seen = 0;
    exp_q.push_back(exp);
    send_opcode(opc);
    @(negedge axis_clk);
    chk("short_latency", 32'({axis_status_valid, axis_status_data}), 32'({1'b1, exp}));
    @(posedge axis_clk); #1;
    drain();
    chk("short_no_req", 32'(req_cnt - req0), 32'd0);
    chk("short_no_ready", 32'(ready_seen), 32'd0);
  endtask

  // Streaming op using wa/wb/wm[0..n-1]; optional B stall on first beat
  task automatic run_stream(input logic [7:0] opc, input int n, input bit need_b,
                            input int b_delay, input logic [1:0] exp);
    int req0 = req_cnt;
    int beat0 = beat_cnt;
    bit ok;
    exp_q.push_back(exp);
    send_opcode(opc);
    for (int i = 0; i < n; i++) begin
      axis_abuff_data  = wa[i];
      axis_bbuff_data  = wb[i];
      axis_mbuff_data  = wm[i];
      axis_abuff_valid = 1'b1;
      axis_mbuff_valid = 1'b1;
      axis_bbuff_valid = !(i == 0 && b_delay > 0);
      if (i == 0) begin
        for (int d = 0; d < b_delay; d++) begin
          @(negedge axis_clk);
          chk("stall_readys", 32'({axis_abuff_ready, axis_bbuff_ready, axis_mbuff_ready}), 32'd0);
          chk("stall_beats", 32'(beat_cnt - beat0), 32'd0);
          @(posedge axis_clk); #1;
        end
        axis_bbuff_valid = 1'b1;
      end
      ok = 0;
      for (int t = 0; t < 50; t++) begin
        @(negedge axis_clk);
        if (axis_abuff_ready) begin ok = 1; break; end
      end
      chk("beat_ready", 32'(ok), 32'd1);
      chk("bbuff_ready", 32'({axis_mbuff_ready, axis_bbuff_ready}), 32'({1'b1, need_b}));
      @(posedge axis_clk); #1;
    end
    axis_abuff_valid = 1'b0;
    axis_bbuff_valid = 1'b0;
    axis_mbuff_valid = 1'b0;
    @(negedge axis_clk);
    chk("stream_latency", 32'(axis_status_valid), 32'd1);
    @(posedge axis_clk); #1;
    drain();
    chk("req_pulses", 32'(req_cnt - req0), 32'd1);
    chk("beat_count", 32'(beat_cnt - beat0), 32'(n));
  endtask

  initial begin
    axis_rstn = 1'b1;
    axis_opcode_data = '0;  axis_opcode_valid = 1'b0;
    axis_abuff_data = '0;   axis_abuff_valid = 1'b0;
    axis_bbuff_data = '0;   axis_bbuff_valid = 1'b0;
    axis_mbuff_data = '0;   axis_mbuff_valid = 1'b0;
    axis_status_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin wa[i] = '0; wb[i] = '0; wm[i] = '0; end

    repeat (3) @(posedge axis_clk);
    #1 axis_rstn = 1'b0;
    @(negedge axis_clk);
    chk("rst_opcode_ready", 32'(axis_opcode_ready), 32'd1);
    chk("rst_status", 32'({axis_status_valid, axis_status_data, stream_reqest}), 32'd0);
    chk("rst_readys", 32'({axis_abuff_ready, axis_bbuff_ready, axis_mbuff_ready}), 32'd0);
    @(posedge axis_clk); #1;

    run_short(8'h17, 2'b11);   // OP 7 invalid
    run_short(8'h00, 2'b01);   // NOP
    run_short(8'h0F, 2'b11);   // OP 15 invalid

    // CMP 2 words equal -> EQ
    wa[0] = 16'h0001; wa[1] = 16'h0002; wm[0] = 16'h0001; wm[1] = 16'h0002;
    wb[0] = 16'hAAAA; wb[1] = 16'h5555;
    run_stream(8'h11, 2, 1'b0, 0, 2'b01);
    // M MSW larger -> LT
    wm[1] = 16'h0003;
    run_stream(8'h11, 2, 1'b0, 0, 2'b00);
    // LSW GT, MSW equal -> GT
    wa[0] = 16'h0005; wa[1] = 16'h0007; wm[0] = 16'h0003; wm[1] = 16'h0007;
    run_stream(8'h11, 2, 1'b0, 0, 2'b10);
    // LSW GT overridden by MSW LT -> LT
    wa[0] = 16'h0009; wa[1] = 16'h0001; wm[0] = 16'h0001; wm[1] = 16'h0002;
    run_stream(8'h11, 2, 1'b0, 0, 2'b00);

    // ADDCMP 1 word: FFFF+1 carries out -> GT
    wa[0] = 16'hFFFF; wb[0] = 16'h0001; wm[0] = 16'hFFFF;
    run_stream(8'h02, 1, 1'b1, 0, 2'b10);
    // ADDCMP 2 words with carry into MSW: {0x0001,0xFFFF}+{0x0000,0x0002} = {0x0002,0x0001}
    wa[0] = 16'hFFFF; wa[1] = 16'h0001; wb[0] = 16'h0002; wb[1] = 16'h0000;
    wm[0] = 16'h0001; wm[1] = 16'h0002;
    run_stream(8'h12, 2, 1'b1, 0, 2'b01);
    // ADDCMP with B stalled 3 cycles: {1,5}+{1,3} = {2,8} == M -> EQ
    wa[0] = 16'h0005; wa[1] = 16'h0001; wb[0] = 16'h0003; wb[1] = 16'h0001;
    wm[0] = 16'h0008; wm[1] = 16'h0002;
    run_stream(8'h12, 2, 1'b1, 3, 2'b01);

    // CMP 16 words: top word A=15 > M=14 decides -> GT
    for (int i = 0; i < 16; i++) begin wa[i] = 16'(i); wm[i] = 16'(i); end
    wm[0] = 16'h0001; wm[15] = 16'h000E;
    run_stream(8'hF1, 16, 1'b0, 0, 2'b10);

`ifdef PUX_SI_SUB_EN
    // SUBCMP 1 word: 3-5 borrows -> LT
    wa[0] = 16'h0003; wb[0] = 16'h0005; wm[0] = 16'h0000;
    run_stream(8'h03, 1, 1'b1, 0, 2'b00);
    // SUBCMP 1 word: 9-4 = 5 == M -> EQ
    wa[0] = 16'h0009; wb[0] = 16'h0004; wm[0] = 16'h0005;
    run_stream(8'h03, 1, 1'b1, 0, 2'b01);
`else
    run_short(8'h03, 2'b11);
`endif

    // Status held under backpressure
    axis_status_ready = 1'b0;
    exp_q.push_back(2'b01);
    send_opcode(8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge axis_clk);
      chk("hold_status", 32'({axis_status_valid, axis_status_data, axis_opcode_ready}), 32'({1'b1, 2'b01, 1'b0}));
      @(posedge axis_clk); #1;
    end
    axis_status_ready = 1'b1;
    drain();
    @(negedge axis_clk);
    chk("ready_after_status", 32'(axis_opcode_ready), 32'd1);
    @(posedge axis_clk); #1;

    // Reset mid-STREAM aborts without a status
    for (int i = 0; i < 4; i++) begin wa[i] = 16'(i); wm[i] = 16'(i); end
    send_opcode(8'h31);
    axis_abuff_data = wa[0]; axis_mbuff_data = wm[0];
    axis_abuff_valid = 1'b1; axis_mbuff_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge axis_clk);
      if (axis_abuff_ready) break;
    end
    chk("abort_beat", 32'(axis_abuff_ready), 32'd1);
    @(posedge axis_clk); #1;
    axis_abuff_valid = 1'b0; axis_mbuff_valid = 1'b0;
    axis_rstn = 1'b1;
    @(posedge axis_clk); #1;
    axis_rstn = 1'b0;
    @(negedge axis_clk);
    chk("abort_idle", 32'({axis_opcode_ready, axis_status_valid, stream_reqest}), 32'({1'b1, 1'b0, 1'b0}));
    @(posedge axis_clk); #1;
    run_short(8'h00, 2'b01);

    repeat (3) @(posedge axis_clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
